// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter sharing one holding register among NREQ requesters,
// with optional ownership lock for burst writes and a bounded lock timeout.
module reg_wr_arbiter #(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int MAXLOCK = 8,
   parameter int IW      = $clog2(NREQ)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ*DW-1:0] din,
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      qout,
   output logic               upd,
   output logic [IW-1:0]      owner,
   output logic               locked
);

   localparam int            CW        = (MAXLOCK > 1) ? $clog2(MAXLOCK) : 1;
   localparam logic [CW-1:0] LCNT_LAST = (MAXLOCK > 0) ? CW'(MAXLOCK - 1) : '0;
   localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t        state, state_nx;
   logic [IW-1:0] ptr, ptr_nx;
   logic [IW-1:0] lown, lown_nx;
   logic [CW-1:0] lcnt, lcnt_nx;
   logic          we;
   logic [IW-1:0] wsel;
   logic [DW-1:0] wdata;
   logic          found;
   logic [IW-1:0] rr_win;

   // Wrap explicitly so non-power-of-two NREQ never lands on an unused index.
   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
      return (i == LAST_IDX) ? '0 : i + IW'(1);
   endfunction

   always_comb begin
      int j;
      found  = 1'b0;
      rr_win = ptr;
      j      = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found  = 1'b1;
            rr_win = IW'(j);
         end
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      lown_nx  = lown;
      lcnt_nx  = lcnt;
      we       = 1'b0;
      wsel     = '0;
      ack      = '0;
      case (state)
         ST_IDLE: begin
            if (found) begin
               we     = 1'b1;
               wsel   = rr_win;
               ptr_nx = next_idx(rr_win);
               if (lock[rr_win]) begin
                  state_nx = ST_LOCKED;
                  lown_nx  = rr_win;
                  lcnt_nx  = '0;
               end
            end
         end
         ST_LOCKED: begin
            we      = req[lown];
            wsel    = lown;
            lcnt_nx = lcnt + CW'(1);
            if (!lock[lown] || ((MAXLOCK != 0) && (lcnt == LCNT_LAST))) begin
               state_nx = ST_IDLE;
               ptr_nx   = next_idx(lown);
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (we && !RST) ack[wsel] = 1'b1;
   end

   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IW'(i) == wsel) wdata = din[i*DW +: DW];
      end
   end

   // Reset wins over any pending write, including one in the middle of a burst.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= ST_IDLE;
         ptr   <= '0;
         lown  <= '0;
         lcnt  <= '0;
         qout  <= '0;
         upd   <= 1'b0;
         owner <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
         lown  <= lown_nx;
         lcnt  <= lcnt_nx;
         upd   <= we;
         if (we) begin
            qout  <= wdata;
            owner <= wsel;
         end
      end
   end

   assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: grants push expected writes, a monitor
// pops and compares them whenever upd is seen.
module tb_reg_wr_arbiter;

   localparam int NREQ    = 4;
   localparam int DW      = 32;
   localparam int MAXLOCK = 8;
   localparam int IW      = 2;

   localparam logic [NREQ*DW-1:0] DIN_ONES = '1;
   localparam logic [NREQ*DW-1:0] DIN_BASE =
      {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
   localparam logic [NREQ*DW-1:0] DIN_RST  =
      {32'hDEAD_BEEF, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ-1:0]    lock = '0;
   logic [NREQ*DW-1:0] din = DIN_ONES;
   logic [NREQ-1:0]    ack;
   logic [DW-1:0]      qout;
   logic               upd;
   logic [IW-1:0]      owner;
   logic               locked;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sbQueue[$];
   exp_t monExp;
   int   testsRun    = 0;
   int   testsFailed = 0;

   reg_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXLOCK(MAXLOCK), .IW(IW)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .req    (req),
      .lock   (lock),
      .din    (din),
      .ack    (ack),
      .qout   (qout),
      .upd    (upd),
      .owner  (owner),
      .locked (locked)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic int onehotIdx(input logic [NREQ-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // One cycle of stimulus: drive at negedge, check combinational ack and the
   // registered locked flag, and queue the write the grant should produce.
   task automatic applyStimulus(input string tag, input logic rst,
                                input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                                input logic [NREQ-1:0] expAck, input logic expLocked,
                                input logic [NREQ*DW-1:0] d);
      exp_t e;
      int   w;
      @(negedge CLK);
      RST  = rst;
      req  = r;
      lock = l;
      din  = d;
      #2;
      checkOutput({tag, " ack"}, DW'(ack), DW'(expAck));
      checkOutput({tag, " locked"}, DW'(locked), DW'(expLocked));
      if (expAck != '0) begin
         w      = onehotIdx(expAck);
         e.idx  = IW'(w);
         e.data = d[w*DW +: DW];
         sbQueue.push_back(e);
      end
   endtask

   always @(negedge CLK) begin
      if (upd === 1'b1) begin
         if (sbQueue.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL upd_unexpected: got upd=1 qout=%h, expected no write", qout);
         end else begin
            monExp = sbQueue.pop_front();
            checkOutput("sb qout", qout, monExp.data);
            checkOutput("sb owner", DW'(owner), DW'(monExp.idx));
         end
      end
   end

   initial begin
      // Reset with every requester active
      applyStimulus("rst0", 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, DIN_ONES);
      applyStimulus("rst1", 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, DIN_ONES);
      applyStimulus("rel0", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, DIN_BASE);
      applyStimulus("rel1", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, DIN_BASE);
      checkOutput("rst qout", qout, 32'h0);
      checkOutput("rst upd", DW'(upd), 32'h0);
      checkOutput("rst owner", DW'(owner), 32'h0);

      // Round-robin fairness
      for (int i = 0; i < 8; i++)
         applyStimulus("rr", 1'b0, 4'b1111, 4'b0000, 4'(1 << (i % 4)), 1'b0, DIN_BASE);

      // Lock burst by requester 2 starving requester 0
      applyStimulus("lb0", 1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b0, DIN_BASE);
      applyStimulus("lb1", 1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b0, DIN_BASE);
      applyStimulus("lb2", 1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b1, DIN_BASE);
      applyStimulus("lb3", 1'b0, 4'b0101, 4'b0100, 4'b0100, 1'b1, DIN_BASE);
      applyStimulus("lb4", 1'b0, 4'b0101, 4'b0000, 4'b0100, 1'b1, DIN_BASE);
      applyStimulus("lb5", 1'b0, 4'b0101, 4'b0000, 4'b0001, 1'b0, DIN_BASE);

      // Timeout: requester 1 holds lock, pointer is at 1
      applyStimulus("to0", 1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b0, DIN_BASE);
      for (int i = 0; i < MAXLOCK; i++)
         applyStimulus("toL", 1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b1, DIN_BASE);
      applyStimulus("to9", 1'b0, 4'b0011, 4'b0010, 4'b0001, 1'b0, DIN_BASE);
      applyStimulus("to10", 1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b0, DIN_BASE);
      applyStimulus("to11", 1'b0, 4'b0011, 4'b0010, 4'b0010, 1'b1, DIN_BASE);
      applyStimulus("to12", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, DIN_BASE);
      applyStimulus("to13", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, DIN_BASE);

      // Idle gap between two writes
      applyStimulus("gw1", 1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, DIN_BASE);
      applyStimulus("gap1", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, DIN_BASE);
      for (int i = 0; i < 2; i++) begin
         applyStimulus("gap", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, DIN_BASE);
         checkOutput("gap upd", DW'(upd), 32'h0);
         checkOutput("gap qout", qout, 32'h1000_0002);
         checkOutput("gap owner", DW'(owner), 32'h2);
      end
      applyStimulus("gw2", 1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, DIN_BASE);
      checkOutput("gw2 upd", DW'(upd), 32'h0);

      // Reset in the middle of a burst by requester 3
      applyStimulus("mb0", 1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b0, DIN_RST);
      applyStimulus("mb1", 1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, DIN_RST);
      applyStimulus("mb2", 1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b1, DIN_RST);
      applyStimulus("mb3", 1'b0, 4'b1010, 4'b0000, 4'b0010, 1'b0, DIN_RST);
      checkOutput("mb qout", qout, 32'h0);
      checkOutput("mb owner", DW'(owner), 32'h0);
      checkOutput("mb upd", DW'(upd), 32'h0);
      applyStimulus("mb4", 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, DIN_RST);

      repeat (3) @(negedge CLK);
      #2;
      checkOutput("sb drained", DW'(sbQueue.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Round-robin write arbiter that shares one DW-bit holding register among NREQ requesters. Each cycle it selects at most one requesting source, captures that source's data into the shared register, and acknowledges it. A requester may lock ownership for back-to-back burst writes, and a bounded lock timeout prevents starvation. It sits in front of the shared configuration and data registers, so multiple masters never drive the same register directly.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..16.
- DW, 32: data width of the shared register.
- MAXLOCK, 8: maximum consecutive cycles in LOCKED state; 0 disables the timeout.
- IW, $clog2(NREQ): width of the requester index.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester write request; bit i belongs to requester i.
- lock  in  NREQ  per-requester lock request; sampled only for the granted requester.
- din  in  NREQ*DW  packed write data; requester i occupies din[i*DW +: DW].
- ack  out  NREQ  one-hot combinational grant; the write is captured at the next edge.
- qout  out  DW  shared register contents.
- upd  out  1  registered pulse, high for the one cycle in which qout shows newly written data.
- owner  out  IW  index of the last requester written; held until the next write.
- locked  out  1  high while in LOCKED state.

## Operation
- State: IDLE or LOCKED; rotating pointer ptr (IW bits); lock owner lown; lock counter lcnt.
- IDLE arbitration:
  - Scan req starting at ptr, ascending, wrapping modulo NREQ.
  - The first set bit w wins, and ack[w]=1 in that cycle.
  - At the edge: qout<=din[w], owner<=w, upd<=1, ptr<=(w+1) mod NREQ.
  - If lock[w]=1 in the same cycle: go to LOCKED, lown<=w, lcnt<=0.
  - If no req is set: ack=0, upd<=0, and all other state is unchanged.
- LOCKED:
  - Only req[lown] is considered; all other requesters get ack=0 even if requesting.
  - If req[lown]=1: ack[lown]=1, qout<=din[lown], upd<=1, owner<=lown.
  - If req[lown]=0: no write, upd<=0.
  - Every LOCKED cycle: lcnt<=lcnt+1.
  - Exit to IDLE at the edge if lock[lown]=0, or if MAXLOCK!=0 and lcnt==MAXLOCK-1.
  - On exit, ptr<=(lown+1) mod NREQ.
  - The exit-cycle write, if any, still completes.
- ack is never multi-hot. ack is 0 while RST=1.
- lock is ignored from any requester that is not currently granted or owning.
- Reset (RST=1 at an edge): qout=0, upd=0, owner=0, locked=0, state IDLE, ptr=0, lcnt=0.
  - Reset has priority over any write in the same cycle, including mid-burst in LOCKED.
- Non-power-of-two NREQ: the pointer wraps at NREQ-1 to 0, never to an unused index.

## Timing
- Latency is 1 cycle: ack in cycle n, then qout, owner and upd valid in cycle n+1.
- Throughput is one write per cycle, sustained in both IDLE and LOCKED.
- A requester holds req and din stable until it sees ack. It may drop req in the cycle after ack.
- If req is held continuously, it is re-arbitrated every cycle. With rotating priority, an unlocked requester waits at most NREQ-1 grants.
- With timeout enabled, worst-case wait is NREQ-1 grants plus (NREQ-1)*MAXLOCK cycles.
- locked is registered; it is high from the cycle after the locking grant through the last LOCKED cycle.
- upd is low in any cycle after an edge with no write, so idle cycles never produce upd pulses.

## Test plan
- Reset values: assert RST for 2 cycles with req=4'b1111 and din all 32'hFFFF_FFFF.
  - Expect ack=0 throughout.
  - After release: qout=0, upd=0, owner=0, locked=0.
- Round-robin fairness: req=4'b1111 held for 8 cycles, din[i]=32'h1000_0000+i, lock=0.
  - Expect ack sequence 0,1,2,3,0,1,2,3.
  - qout follows one cycle later, with upd=1 each cycle.
- Lock burst: from ptr=0, req=4'b0101 with lock[2]=1 for 3 cycles, then lock[2]=0.
  - Expect requester 0 granted first.
  - Then requester 2 is granted 4 consecutive times while requester 0 is starved.
  - Then locked falls and requester 0 is granted next (ptr=3 wraps to 0).
- Timeout: MAXLOCK=8, req=4'b0011, lock[1] held high.
  - Expect requester 1 holds exactly 8 LOCKED cycles.
  - Then IDLE is forced and requester 0 is granted next.
  - locked=0 for at least one cycle.
- Mid-burst reset: RST pulsed for 1 cycle during a LOCKED burst with req[3]=1.
  - Expect no capture of din[3] in that cycle.
  - qout=0, locked=0, ptr=0 afterwards.
  - Next grant goes to the lowest requesting index.
- Idle gap and upd: req=0 for 3 cycles between two writes.
  - Expect upd=0 and qout/owner unchanged during the gap.
  - upd=1 only in the cycle after each ack.
